// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer
// Description : Command FIFO plus burst expander producing 64-bit array
//               controller instruction words, one beat per issue cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [4:0]       cmd_opcode,
   input  logic [15:0]      cmd_addr,
   input  logic [15:0]      cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             issue_en,
   output logic [63:0]      instruction,
   output logic             instr_valid,
   output logic             cmd_err,
   output logic             busy
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENTRY_W = 5 + 16 + 16 + LEN_W;
   localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [4:0]         cur_op_q, cur_op_d;
   logic [15:0]        cur_addr_q, cur_addr_d;
   logic [15:0]        cur_data_q, cur_data_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [63:0]        instruction_q, instruction_d;
   logic               instr_valid_q, instr_valid_d;
   logic               cmd_err_q, cmd_err_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

   logic               is_burst_op;
   logic               is_single_op;
   logic               handshake;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;
   logic [4:0]         head_op;
   logic [15:0]        head_addr;
   logic [15:0]        head_data;
   logic [LEN_W-1:0]   head_len;

   always_comb begin
      is_burst_op  = 1'b0;
      is_single_op = 1'b0;
      case (cmd_opcode)
         5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b11111: is_burst_op  = 1'b1;
         5'b00100, 5'b00101:                               is_single_op = 1'b1;
         default: ;
      endcase
   end

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q != c_full_count) && !rst;
   assign handshake  = cmd_valid && cmd_ready;
   assign push       = handshake && (is_burst_op || is_single_op);
   assign cmd_err_d  = handshake &&
                       (!(is_burst_op || is_single_op) || (is_single_op && (cmd_len != '0)));

   // Receive ops carry data and are always one beat; everything else issues data as zero.
   assign wr_entry = {cmd_opcode, cmd_addr,
                      is_single_op ? cmd_data : 16'h0000,
                      is_single_op ? {LEN_W{1'b0}} : cmd_len};

   assign head      = mem_q[rd_ptr_q];
   assign head_op   = head[ENTRY_W-1 -: 5];
   assign head_addr = head[ENTRY_W-6 -: 16];
   assign head_data = head[LEN_W+15 -: 16];
   assign head_len  = head[LEN_W-1:0];

   always_comb begin
      state_d       = state_q;
      cur_op_d      = cur_op_q;
      cur_addr_d    = cur_addr_q;
      cur_data_d    = cur_data_q;
      remaining_d   = remaining_q;
      instruction_d = 64'h0;
      instr_valid_d = 1'b0;
      pop           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue_en && !fifo_empty) begin
               pop           = 1'b1;
               instruction_d = {head_op, head_addr, head_data, 27'h0};
               instr_valid_d = 1'b1;
               cur_op_d      = head_op;
               cur_data_d    = head_data;
               cur_addr_d    = head_addr + 16'h0001;
               remaining_d   = head_len;
               if (head_len != '0) begin
                  state_d = S_BURST;
               end
            end
         end
         S_BURST: begin
            if (issue_en) begin
               instruction_d = {cur_op_q, cur_addr_q, cur_data_q, 27'h0};
               instr_valid_d = 1'b1;
               cur_addr_d    = cur_addr_q + 16'h0001;
               remaining_d   = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cur_op_q      <= '0;
         cur_addr_q    <= '0;
         cur_data_q    <= '0;
         remaining_q   <= '0;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
         cmd_err_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         cur_op_q      <= cur_op_d;
         cur_addr_q    <= cur_addr_d;
         cur_data_q    <= cur_data_d;
         remaining_q   <= remaining_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         cmd_err_q     <= cmd_err_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   assign instruction = instruction_q;
   assign instr_valid = instr_valid_q;
   assign cmd_err     = cmd_err_q;
   assign busy        = !fifo_empty || (state_q == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_issuer
// Description : Directed bench for instr_issuer with a beat-queue reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [4:0]  cmd_opcode = '0;
   logic [15:0] cmd_addr = '0;
   logic [15:0] cmd_data = '0;
   logic [3:0]  cmd_len = '0;
   logic        issue_en = 1'b1;
   logic [63:0] instruction;
   logic        instr_valid;
   logic        cmd_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   instr_issuer #(.FIFO_DEPTH(8), .LEN_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_len    (cmd_len),
      .issue_en   (issue_en),
      .instruction(instruction),
      .instr_valid(instr_valid),
      .cmd_err    (cmd_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every accepted command is expanded at once into its beats;
   // each enabled edge hands out the oldest beat.
   typedef struct {
      bit          first;
      logic [63:0] w;
   } beat_t;
   typedef struct {
      int          cyc;
      logic [63:0] w;
   } log_t;

   beat_t       bq[$];
   log_t        ilog[$];
   int          m_count = 0;
   int          cyc = 0;
   logic [63:0] e_instr = '0;
   logic        e_valid = 1'b0;
   logic        e_err = 1'b0;

   always @(posedge clk) begin
      beat_t b;
      bit    acc, single, burst;
      int    nb;
      acc = cmd_valid && !rst && (m_count < 8);
      if (rst) begin
         bq.delete();
         m_count = 0;
         e_instr = '0;
         e_valid = 1'b0;
         e_err   = 1'b0;
      end else begin
         e_instr = '0;
         e_valid = 1'b0;
         e_err   = 1'b0;
         if (issue_en && bq.size() > 0) begin
            b = bq.pop_front();
            e_instr = b.w;
            e_valid = 1'b1;
            if (b.first) m_count--;
         end
         if (acc) begin
            single = (cmd_opcode == 5'd4) || (cmd_opcode == 5'd5);
            burst  = cmd_opcode inside {5'd1, 5'd2, 5'd3, 5'd6, 5'd31};
            if (!single && !burst) begin
               e_err = 1'b1;
            end else begin
               if (single && cmd_len != 4'd0) e_err = 1'b1;
               nb = single ? 1 : int'(cmd_len) + 1;
               for (int i = 0; i < nb; i++)
                  bq.push_back('{first: (i == 0),
                                 w: {cmd_opcode, 16'(int'(cmd_addr) + i),
                                     single ? cmd_data : 16'h0, 27'h0}});
               m_count++;
            end
         end
      end
      cyc++;
      #1;
      chk("instruction", instruction, e_instr);
      chk("instr_valid", 64'(instr_valid), 64'(e_valid));
      chk("cmd_err", 64'(cmd_err), 64'(e_err));
      chk("busy", 64'(busy), 64'(bq.size() > 0));
      chk("cmd_ready", 64'(cmd_ready), 64'(!rst && m_count < 8));
      if (instr_valid === 1'b1) ilog.push_back('{cyc: cyc, w: instruction});
   end

   // Returns one time unit after the handshake edge with cmd_valid already dropped.
   task automatic push(input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] d, input logic [3:0] l);
      int n = 0;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_addr   = a;
      cmd_data   = d;
      cmd_len    = l;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("push_timeout", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log;
      @(negedge clk);
      ilog.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_instruction", instruction, 64'h0);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(cmd_err), 64'd0);
      chk("rst_ready_low", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_rst", 64'(cmd_ready), 64'd1);

      // 1: receive-inputs single beat
      clear_log();
      push(5'b00100, 16'h0010, 16'h1234, 4'd0);
      @(posedge clk);
      #1;
      chk("t1_word", instruction, 64'h2000_8091_A000_0000);
      chk("t1_valid", 64'(instr_valid), 64'd1);
      @(posedge clk);
      #1 chk("t1_after", {instruction[63:1], instr_valid}, 64'h0);

      // 2: burst across 0x1000 with a second command queued behind it
      clear_log();
      push(5'b00001, 16'h0FFE, 16'h5555, 4'd3);
      push(5'b00011, 16'h2000, 16'h0000, 4'd0);
      wait_cycles(8);
      chk("t2_count", 64'(ilog.size()), 64'd5);
      if (ilog.size() == 5) begin
         chk("t2_b0", ilog[0].w, {5'b00001, 16'h0FFE, 16'h0, 27'h0});
         chk("t2_b1", ilog[1].w, {5'b00001, 16'h0FFF, 16'h0, 27'h0});
         chk("t2_b2", ilog[2].w, {5'b00001, 16'h1000, 16'h0, 27'h0});
         chk("t2_b3", ilog[3].w, {5'b00001, 16'h1001, 16'h0, 27'h0});
         chk("t2_next", ilog[4].w, {5'b00011, 16'h2000, 16'h0, 27'h0});
         chk("t2_no_bubble", 64'(ilog[4].cyc - ilog[0].cyc), 64'd4);
      end

      // 3: address wrap
      clear_log();
      push(5'b00010, 16'hFFFF, 16'h1111, 4'd1);
      wait_cycles(5);
      chk("t3_count", 64'(ilog.size()), 64'd2);
      if (ilog.size() == 2) begin
         chk("t3_b0", ilog[0].w, {5'b00010, 16'hFFFF, 16'h0, 27'h0});
         chk("t3_b1", ilog[1].w, {5'b00010, 16'h0000, 16'h0, 27'h0});
      end

      // 4: two-cycle stall after the second beat
      clear_log();
      push(5'b00001, 16'h0100, 16'h0000, 4'd3);
      repeat (2) @(posedge clk);
      #1 issue_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 issue_en = 1'b1;
      wait_cycles(5);
      chk("t4_count", 64'(ilog.size()), 64'd4);
      if (ilog.size() == 4) begin
         chk("t4_b1", ilog[1].w, {5'b00001, 16'h0101, 16'h0, 27'h0});
         chk("t4_b2", ilog[2].w, {5'b00001, 16'h0102, 16'h0, 27'h0});
         chk("t4_b3", ilog[3].w, {5'b00001, 16'h0103, 16'h0, 27'h0});
         chk("t4_gap", 64'(ilog[2].cyc - ilog[1].cyc), 64'd3);
      end

      // 5: fill the FIFO while stalled, then drain
      clear_log();
      issue_en = 1'b0;
      for (int i = 0; i < 8; i++) push(5'b00110, 16'(16'h3000 + i), 16'h0, 4'd0);
      chk("t5_full_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opcode = 5'b00110;
      cmd_addr   = 16'h3008;
      repeat (3) begin
         @(posedge clk);
         #1 chk("t5_held_off", 64'(cmd_ready), 64'd0);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      issue_en  = 1'b1;
      @(posedge clk);
      #1 chk("t5_ready_back", 64'(cmd_ready), 64'd1);
      wait_cycles(12);
      chk("t5_count", 64'(ilog.size()), 64'd8);
      if (ilog.size() == 8)
         for (int i = 0; i < 8; i++)
            chk("t5_order", ilog[i].w, {5'b00110, 16'(16'h3000 + i), 16'h0, 27'h0});

      // 6a: illegal opcode
      clear_log();
      push(5'b00111, 16'h0A00, 16'h0, 4'd0);
      chk("t6a_err", 64'(cmd_err), 64'd1);
      @(posedge clk);
      #1 chk("t6a_err_drop", 64'(cmd_err), 64'd0);
      wait_cycles(3);
      chk("t6a_nothing", 64'(ilog.size()), 64'd0);

      // 6b: single-beat opcode with nonzero length
      clear_log();
      push(5'b00101, 16'h4000, 16'hBEEF, 4'd2);
      chk("t6b_err", 64'(cmd_err), 64'd1);
      wait_cycles(5);
      chk("t6b_count", 64'(ilog.size()), 64'd1);
      if (ilog.size() == 1) chk("t6b_word", ilog[0].w, {5'b00101, 16'h4000, 16'hBEEF, 27'h0});

      // 6c: reset mid-burst
      clear_log();
      push(5'b00001, 16'h5000, 16'h0, 4'd7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6c_instr", instruction, 64'h0);
      chk("t6c_valid", 64'(instr_valid), 64'd0);
      chk("t6c_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(5);
      chk("t6c_count", 64'(ilog.size()), 64'd2);
      chk("t6c_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
